fp16_seq_multiplier: RTL and testbench

- Iterative FP16 (1/5/10) multiplier that produces the product term of the MAC unit.
- Its result feeds the operand port of the downstream FP16 adder; the accumulator value supplies the adder's other operand.
- Shift-add mantissa multiply, one partial product per clock, with valid/ready handshakes on both sides.
- Truncating, with no rounding, to match the adder's truncation behaviour.

---
 rtl/fp16_pkg.sv | 22 ++
 rtl/fp16_mul_normaliser.sv | 33 +++
 rtl/fp16_seq_multiplier.sv | 106 ++++++++++
 tb/tb_fp16_seq_multiplier.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 field layout, special encodings and multiplier FSM states.
package fp16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int FRAC_W   = 10;
  localparam int PROD_W   = 22;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

  // Subnormals share exponent 1 with the smallest normal, only the hidden bit differs.
  function automatic logic [4:0] eff_exp(input logic [15:0] x);
    return (x[EXP_MSB:EXP_LSB] == 5'd0) ? 5'd1 : x[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/fp16_mul_normaliser.sv
// Places the leading one of the raw 22-bit product at bit 20 and adjusts the exponent.
module fp16_mul_normaliser
  import fp16_pkg::*;
(
  input  logic [PROD_W-1:0] p_i,
  input  logic signed [7:0] e_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic signed [7:0] e_o,
  output logic              zero_o
);

  logic [4:0] lz;

  always_comb begin
    // Scan upward so the highest set bit below 20 wins.
    lz = 5'd20;
    for (int i = 0; i < 20; i++)
      if (p_i[i]) lz = 5'(20 - i);

    zero_o = (p_i == '0);
    if (p_i[21]) begin
      frac_o = p_i[20:11];
      e_o    = e_i + 8'sd1;
    end else if (p_i[20]) begin
      frac_o = p_i[19:10];
      e_o    = e_i;
    end else begin
      frac_o = 10'((p_i << lz) >> 10);
      e_o    = e_i - $signed({3'b000, lz});
    end
  end

endmodule

// File: rtl/fp16_seq_multiplier.sv
// Iterative truncating FP16 multiplier: one shift-add partial product per clock.
module fp16_seq_multiplier
  import fp16_pkg::*;
#(
  parameter int MANT_W   = 11,
  parameter int EXP_BIAS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
);

  localparam int PW = 2 * MANT_W;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [15:0]       a_q, b_q, res_q, res_d;
  logic [PW-1:0]     p_q;
  logic [MANT_W-1:0] asig, bsig;
  logic signed [7:0] e_sum, e_n;
  logic [FRAC_W-1:0] frac;
  logic              p_zero, sign, a_inf, b_inf, a_zero, b_zero;

  assign asig = {|a_q[EXP_MSB:EXP_LSB], a_q[FRAC_W-1:0]};
  assign bsig = {|b_q[EXP_MSB:EXP_LSB], b_q[FRAC_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)                  state_d = MUL;
      MUL:  if (cnt_q == 4'(MANT_W - 1))   state_d = NORM;
      NORM:                                state_d = DONE;
      DONE: if (out_ready)                 state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          p_q   <= '0;
          cnt_q <= '0;
        end
        MUL: begin
          if (bsig[cnt_q]) p_q <= p_q + (PW'(asig) << cnt_q);
          cnt_q <= cnt_q + 4'd1;
        end
        NORM:    res_q <= res_d;
        default: ;
      endcase
    end
  end

  assign e_sum = $signed({3'b000, eff_exp(a_q)}) + $signed({3'b000, eff_exp(b_q)})
               - 8'(EXP_BIAS);

  fp16_mul_normaliser u_norm (
    .p_i    (p_q),
    .e_i    (e_sum),
    .frac_o (frac),
    .e_o    (e_n),
    .zero_o (p_zero)
  );

  always_comb begin
    sign   = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
    a_inf  = (a_q[EXP_MSB:EXP_LSB] == 5'(EXP_MAX));
    b_inf  = (b_q[EXP_MSB:EXP_LSB] == 5'(EXP_MAX));
    a_zero = (a_q[EXP_MSB:0] == 15'd0);
    b_zero = (b_q[EXP_MSB:0] == 15'd0);
    // Specials are resolved ahead of the numeric path; NaN inputs are treated as Inf.
    if ((a_inf && b_zero) || (b_inf && a_zero)) res_d = FP16_QNAN;
    else if (a_inf || b_inf)                    res_d = {sign, FP16_POS_INF[EXP_MSB:0]};
    else if (p_zero)                            res_d = {sign, 15'd0};
    else if (e_n >= 8'(EXP_MAX))                res_d = {sign, FP16_POS_INF[EXP_MSB:0]};
    else if (e_n <= 8'sd0)                      res_d = {sign, 15'd0};
    else                                        res_d = {sign, e_n[4:0], frac};
  end

endmodule

// File: tb/tb_fp16_seq_multiplier.sv
// Vector table plus backpressure and mid-operation reset sequences for the FP16 multiplier.
module tb_fp16_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;

  int n_tot = 0;
  int n_pass = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t tv[18];

  fp16_seq_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Launches one operation and checks both its latency and its scoreboarded result.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                       input logic [15:0] xexp, input string nm);
    int n;
    logic [15:0] e;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({nm, "_ready_timeout"}, 0, 1);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    sb.push_back(xexp);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, 13);
    if (sb.size() == 0) chk({nm, "_sb_empty"}, 0, 1);
    else begin
      e = sb.pop_front();
      chk(nm, result, e);
    end
  endtask

  initial begin
    int bad_stable, bad_ready, n;
    tv[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, "one_x_one"};
    tv[1]  = '{16'h4000, 16'hC200, 16'hC600, "two_x_m3"};
    tv[2]  = '{16'h3E00, 16'h3E00, 16'h4080, "carry_1p5sq"};
    tv[3]  = '{16'h3555, 16'h4200, 16'h3BFF, "trunc_noround"};
    tv[4]  = '{16'h7BFF, 16'h4000, 16'h7C00, "overflow"};
    tv[5]  = '{16'h0400, 16'h0400, 16'h0000, "underflow_pos"};
    tv[6]  = '{16'h8400, 16'h0400, 16'h8000, "underflow_neg"};
    tv[7]  = '{16'h7C00, 16'h0000, 16'h7E00, "inf_x_zero"};
    tv[8]  = '{16'hFC00, 16'h3C00, 16'hFC00, "ninf_x_one"};
    tv[9]  = '{16'h0000, 16'hC000, 16'h8000, "zero_x_m2"};
    tv[10] = '{16'h0200, 16'h4800, 16'h0C00, "subnorm_x_8"};
    tv[11] = '{16'h0000, 16'h7C00, 16'h7E00, "zero_x_inf"};
    tv[12] = '{16'h7C00, 16'h7C00, 16'h7C00, "inf_x_inf"};
    tv[13] = '{16'h0001, 16'h7800, 16'h1800, "min_sub_renorm"};
    tv[14] = '{16'h3FFF, 16'h3FFF, 16'h43FE, "carry_trunc"};
    tv[15] = '{16'h7BFF, 16'h3C00, 16'h7BFF, "max_normal"};
    tv[16] = '{16'h0400, 16'h3C00, 16'h0400, "min_normal"};
    tv[17] = '{16'h3800, 16'h3A00, 16'h3600, "half_x_3q"};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) do_op(tv[i].a, tv[i].b, tv[i].exp, tv[i].name);

    // Backpressure: result must hold and new operands must be ignored.
    @(negedge clk);
    out_ready = 1'b0;
    do_op(16'h3C00, 16'h4000, 16'h4000, "bp_result");
    bad_stable = 0;
    bad_ready = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c >= 5);
      a = 16'h4400;
      b = 16'h4400;
      @(negedge clk);
      if (result !== 16'h4000 || out_valid !== 1'b1) bad_stable++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    chk("bp_stable_cycles_bad", bad_stable, 0);
    chk("bp_in_ready_cycles_bad", bad_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_result_kept", result, 16'h4000);

    // Reset five cycles into MUL abandons the operation.
    in_valid = 1'b1;
    a = 16'h4200;
    b = 16'h4200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 16'h0000);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midrst_no_output", n, 0);
    do_op(16'h4200, 16'h4200, 16'h4880, "midrst_next_op");
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
